watch_set_ctrl: RTL



---
 rtl/watch_set_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/watch_set_ctrl.sv
// Manual time-set sequencer: turns debounced button levels into set-mode control,
// field selection, inc/dec strobes with hold auto-repeat, inactivity timeout and blink.
module watch_set_ctrl #(
    parameter int HOLD_DLY_MS = 500,
    parameter int RPT_MS      = 100,
    parameter int TIMEOUT_MS  = 10000,
    parameter int BLINK_MS    = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick_1khz,
    input  logic       i_btnC,
    input  logic       i_btnL,
    input  logic       i_btnR,
    input  logic       i_btnU,
    input  logic       i_btnD,
    output logic       o_set_mode,
    output logic [1:0] o_field,
    output logic       o_inc,
    output logic       o_dec,
    output logic       o_blank
);
    localparam int HW = $clog2(HOLD_DLY_MS + 1);
    localparam int TW = $clog2(TIMEOUT_MS + 1);
    localparam int BW = $clog2(BLINK_MS + 1);

    // The hold counter reloads so the same threshold yields RPT_MS-tick spacing after the first strobe.
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_DLY_MS - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_DLY_MS - RPT_MS);
    localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_MS);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_MS - 1);

    localparam int B_D = 0;
    localparam int B_U = 1;
    localparam int B_R = 2;
    localparam int B_L = 3;
    localparam int B_C = 4;

    localparam logic [1:0] F_SEC  = 2'd0;
    localparam logic [1:0] F_HOUR = 2'd2;

    typedef enum logic [1:0] {ST_RUN, ST_SET, ST_HOLD_U, ST_HOLD_D} state_t;

    state_t          state_q, state_d;
    logic [1:0]      field_q, field_d;
    logic            inc_q, inc_d;
    logic            dec_q, dec_d;
    logic            blank_q, blank_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   to_q, to_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic [4:0]      prev_q, prev_d;
    logic [4:0]      btn;
    logic [4:0]      rise;
    logic            held;

    assign btn    = {i_btnC, i_btnL, i_btnR, i_btnU, i_btnD};
    assign prev_d = btn;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_edge
            assign rise[gi] = btn[gi] & ~prev_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        blank_d = blank_q;
        hold_d  = hold_q;
        to_d    = to_q;
        blink_d = blink_q;
        held    = 1'b0;
        case (state_q)
            ST_RUN: begin
                field_d = F_SEC;
                blank_d = 1'b0;
                hold_d  = '0;
                to_d    = '0;
                blink_d = '0;
                if (rise[B_C]) begin
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                hold_d = '0;
                if (i_tick_1khz) begin
                    if (to_q != TO_MAX) begin
                        to_d = to_q + TW'(1);
                    end
                    if (blink_q == BLINK_LAST) begin
                        blink_d = '0;
                        blank_d = ~blank_q;
                    end else begin
                        blink_d = blink_q + BW'(1);
                    end
                end
                // Every edge is honoured here, so any press restarts timeout and blink phase.
                if (|rise) begin
                    to_d    = '0;
                    blink_d = '0;
                    blank_d = 1'b0;
                end
                if (rise[B_C]) begin
                    state_d = ST_RUN;
                    field_d = F_SEC;
                end else if (rise[B_L]) begin
                    field_d = (field_q == F_HOUR) ? F_SEC : field_q + 2'd1;
                end else if (rise[B_R]) begin
                    field_d = (field_q == F_SEC) ? F_HOUR : field_q - 2'd1;
                end else if (rise[B_U]) begin
                    inc_d   = 1'b1;
                    state_d = ST_HOLD_U;
                end else if (rise[B_D]) begin
                    dec_d   = 1'b1;
                    state_d = ST_HOLD_D;
                end else if (to_q == TO_MAX) begin
                    state_d = ST_RUN;
                    field_d = F_SEC;
                    blank_d = 1'b0;
                end
            end
            default: begin
                to_d    = '0;
                blink_d = '0;
                blank_d = 1'b0;
                held    = (state_q == ST_HOLD_U) ? i_btnU : i_btnD;
                if (rise[B_C]) begin
                    state_d = ST_RUN;
                    field_d = F_SEC;
                    hold_d  = '0;
                end else if (!held) begin
                    state_d = ST_SET;
                    hold_d  = '0;
                end else if (i_tick_1khz) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = HOLD_RELOAD;
                        if (state_q == ST_HOLD_U) begin
                            inc_d = 1'b1;
                        end else begin
                            dec_d = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            field_q <= F_SEC;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            blank_q <= 1'b0;
            hold_q  <= '0;
            to_q    <= '0;
            blink_q <= '0;
            prev_q  <= '1;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            blank_q <= blank_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            blink_q <= blink_d;
            prev_q  <= prev_d;
        end
    end

    assign o_set_mode = (state_q != ST_RUN);
    assign o_field    = field_q;
    assign o_inc      = inc_q;
    assign o_dec      = dec_q;
    assign o_blank    = blank_q;

endmodule
